arty_rst_seq: RTL and testbench



---
 rtl/arty_rst_seq.sv | 135 +++++++++++++
 tb/tb_arty_rst_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/arty_rst_seq.sv
//==============================================================================
// arty_rst_seq - MMCM -> peripheral -> CPU reset sequencer; define ARTY_RST_SEQ_LOCK_TIMEOUT_EN for lock-timeout retry.
// Revision: 1.0
//==============================================================================
`default_nettype none

module arty_rst_seq #(
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int PERIPH_DLY      = 8,
  parameter int WARM_CYCLES     = 4,
  parameter int CW              = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       mmcm_locked,
  input  logic       sysresetreq,
  output logic       mmcm_resetn,
  output logic       periph_resetn,
  output logic       cpu_resetn,
  output logic       sys_ready,
  output logic [3:0] retry_cnt
);

`ifdef ARTY_RST_SEQ_LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CW-1:0] MMCM_LAST   = CW'(MMCM_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PERIPH_LAST = CW'(PERIPH_DLY - 1);
  localparam logic [CW-1:0] WARM_LAST   = CW'(WARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_MMCM_RST  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_PERIPH    = 3'd2,
    S_CPU_REL   = 3'd3,
    S_RUN       = 3'd4,
    S_WARM      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          retry_inc;
  logic          lock_meta;
  logic          lock_s;
  logic          srr_meta;
  logic          srr_s;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      srr_meta  <= 1'b0;
      srr_s     <= 1'b0;
    end else begin
      lock_meta <= mmcm_locked;
      lock_s    <= lock_meta;
      srr_meta  <= sysresetreq;
      srr_s     <= srr_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    retry_inc = 1'b0;
    case (state)
      S_MMCM_RST: begin
        if (cnt == MMCM_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_PERIPH;
        end else if (TIMEOUT_EN && (cnt == LOCK_LAST)) begin
          state_nxt = S_MMCM_RST;
          retry_inc = 1'b1;
        end
      end
      S_PERIPH: begin
        if (!lock_s)                state_nxt = S_MMCM_RST;
        else if (cnt == PERIPH_LAST) state_nxt = S_CPU_REL;
      end
      S_CPU_REL: begin
        state_nxt = lock_s ? S_RUN : S_MMCM_RST;
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!lock_s)    state_nxt = S_MMCM_RST;
        else if (srr_s) state_nxt = S_WARM;
      end
      S_WARM: begin
        if (!lock_s) begin
          state_nxt = S_MMCM_RST;
        end else if (cnt == WARM_LAST) begin
          // Hold the count while the request is still asserted.
          cnt_nxt = cnt;
          if (!srr_s) state_nxt = S_CPU_REL;
        end
      end
      default: state_nxt = S_MMCM_RST;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state         <= S_MMCM_RST;
      cnt           <= '0;
      retry_cnt     <= 4'd0;
      mmcm_resetn   <= 1'b0;
      periph_resetn <= 1'b0;
      cpu_resetn    <= 1'b0;
      sys_ready     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      if (retry_inc && (retry_cnt != 4'hF)) retry_cnt <= retry_cnt + 4'd1;
      mmcm_resetn   <= (state_nxt != S_MMCM_RST);
      periph_resetn <= (state_nxt == S_PERIPH) || (state_nxt == S_CPU_REL) ||
                       (state_nxt == S_RUN)    || (state_nxt == S_WARM);
      cpu_resetn    <= (state_nxt == S_CPU_REL) || (state_nxt == S_RUN);
      sys_ready     <= (state_nxt == S_RUN);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arty_rst_seq.sv
//==============================================================================
// tb_arty_rst_seq - directed self-checking bench for arty_rst_seq (default parameters).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_arty_rst_seq;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       mmcm_locked;
  logic       sysresetreq;
  logic       mmcm_resetn;
  logic       periph_resetn;
  logic       cpu_resetn;
  logic       sys_ready;
  logic [3:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  arty_rst_seq dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .mmcm_locked   (mmcm_locked),
    .sysresetreq   (sysresetreq),
    .mmcm_resetn   (mmcm_resetn),
    .periph_resetn (periph_resetn),
    .cpu_resetn    (cpu_resetn),
    .sys_ready     (sys_ready),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp);
    chk(tag, {mmcm_resetn, periph_resetn, cpu_resetn, sys_ready, 1'b0}, {exp[4:1], 1'b0});
  endtask

  initial begin
    int n;
    int lows;
    reset       = 1'b1;
    mmcm_locked = 1'b1;
    sysresetreq = 1'b0;
    tick(3);
    chk_outs("reset_outs", 5'b0000_0);
    chk("reset_retry", 32'(retry_cnt), 0);

    // Cold start with lock already present.
    reset = 1'b0;
    tick(15);
    chk("cold_mmcm_low15", 32'(mmcm_resetn), 0);
    tick(1);
    chk("cold_mmcm_rise16", 32'(mmcm_resetn), 1);
    chk("cold_periph_low", 32'(periph_resetn), 0);
    n = 0;
    while (periph_resetn !== 1'b1 && n < 6) begin
      tick(1);
      n++;
    end
    chk("cold_periph_lat_ok", 32'(n >= 1 && n <= 4), 1);
    tick(7);
    chk("cold_cpu_low", 32'(cpu_resetn), 0);
    tick(1);
    chk("cold_cpu_rise", 32'(cpu_resetn), 1);
    chk("cold_ready_lag", 32'(sys_ready), 0);
    tick(1);
    chk_outs("cold_run", 5'b1111_0);
    chk("cold_retry", 32'(retry_cnt), 0);

    // Warm reset, one-cycle request.
    sysresetreq = 1'b1;
    tick(1);
    sysresetreq = 1'b0;
    tick(1);
    chk("warm1_still_run", 32'(sys_ready), 1);
    tick(1);
    chk_outs("warm1_enter", 5'b1100_0);
    tick(3);
    chk_outs("warm1_4th", 5'b1100_0);
    tick(1);
    chk_outs("warm1_cpu_rel", 5'b1110_0);
    tick(1);
    chk_outs("warm1_run", 5'b1111_0);

    // Warm reset held for 20 cycles.
    sysresetreq = 1'b1;
    tick(10);
    chk_outs("warm20_mid", 5'b1100_0);
    tick(10);
    sysresetreq = 1'b0;
    tick(2);
    chk_outs("warm20_rel2", 5'b1100_0);
    tick(1);
    chk_outs("warm20_rel3", 5'b1110_0);
    tick(1);
    chk_outs("warm20_run", 5'b1111_0);

    // Lock loss in RUN, then full replay.
    mmcm_locked = 1'b0;
    tick(2);
    chk_outs("loss_2edges", 5'b1111_0);
    tick(1);
    chk_outs("loss_3edges", 5'b0000_0);
    mmcm_locked = 1'b1;
    tick(15);
    chk("replay_mmcm_low", 32'(mmcm_resetn), 0);
    tick(1);
    chk_outs("replay_mmcm_rise", 5'b1000_0);
    tick(1);
    chk_outs("replay_periph", 5'b1100_0);
    tick(8);
    chk_outs("replay_cpu", 5'b1110_0);
    tick(1);
    chk_outs("replay_run", 5'b1111_0);

    // Simultaneous lock loss and warm request.
    mmcm_locked = 1'b0;
    sysresetreq = 1'b1;
    tick(3);
    chk_outs("simul_mmcm_rst", 5'b0000_0);
    mmcm_locked = 1'b1;
    sysresetreq = 1'b0;
    tick(5);
    chk_outs("simul_stay_rst", 5'b0000_0);
    tick(11);
    chk_outs("simul_mmcm_rise", 5'b1000_0);
    tick(1);
    chk_outs("simul_periph", 5'b1100_0);
    tick(9);
    chk_outs("simul_run", 5'b1111_0);

    // Async reset in the middle of PERIPH.
    mmcm_locked = 1'b0;
    tick(3);
    mmcm_locked = 1'b1;
    tick(17);
    chk_outs("mid_periph_in", 5'b1100_0);
    #2;
    reset       = 1'b1;
    mmcm_locked = 1'b0;
    #1;
    chk_outs("async_reset_outs", 5'b0000_0);
    chk("async_reset_retry", 32'(retry_cnt), 0);
    tick(2);
    reset = 1'b0;
    tick(15);
    chk("restart_mmcm_low", 32'(mmcm_resetn), 0);
    tick(1);
    chk_outs("restart_wait_lock", 5'b1000_0);
    tick(5);
    chk_outs("restart_waiting", 5'b1000_0);
    mmcm_locked = 1'b1;
    tick(2);
    chk("lock_lat_2", 32'(periph_resetn), 0);
    tick(1);
    chk("lock_lat_3", 32'(periph_resetn), 1);
    tick(7);
    chk("restart_cpu_low", 32'(cpu_resetn), 0);
    tick(1);
    chk("restart_cpu_rise", 32'(cpu_resetn), 1);
    tick(1);
    chk_outs("restart_run", 5'b1111_0);

    // No lock at all after a cold reset.
    reset       = 1'b1;
    mmcm_locked = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(16);
    chk("nolock_mmcm_rise", 32'(mmcm_resetn), 1);
`ifdef ARTY_RST_SEQ_LOCK_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      tick(4095);
      chk("to_before", 32'(mmcm_resetn), 1);
      tick(1);
      chk("to_mmcm_low", 32'(mmcm_resetn), 0);
      chk("to_retry", 32'(retry_cnt), 32'(i));
      tick(15);
      chk("to_pulse_hold", 32'(mmcm_resetn), 0);
      tick(1);
      chk("to_pulse_end", 32'(mmcm_resetn), 1);
    end
    for (int i = 4; i <= 16; i++) begin
      tick(4096);
      chk("to_retry_sat", 32'(retry_cnt), (i > 15) ? 32'd15 : 32'(i));
      tick(16);
    end
    reset = 1'b1;
    #1;
    chk("to_retry_cleared", 32'(retry_cnt), 0);
    reset = 1'b0;
`else
    lows = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (mmcm_resetn !== 1'b1) lows++;
    end
    chk("nolock_never_retries", 32'(lows), 0);
    chk("nolock_retry_zero", 32'(retry_cnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
